pq_pop_unit: RTL and testbench
==============================

// Module: pq_pop_unit
// PURPOSE
//   Downstream consumer of PQ_FIFO. Issues single-cycle dequeue pulses when the queue
//   is non-empty and there is room downstream. Captures each popped word and splits it
//   into {priority, payload}. Presents the result on a valid/ready stream through a
//   2-entry output buffer. Feeds the search/expansion stage and flags a dequeue that is
//   never answered.
// PARAMETERS
//   DATA_WIDTH  32   width of PQ_FIFO data_out word
//   PRIO_WIDTH  16   upper bits of the word = priority; remaining low bits = payload
//   TIMEOUT     15   max cycles from a dequeue pulse to pq_valid_in before error (>=1)
//   CNT_WIDTH   16   width of pop counter
// PORTS
//   clk_in          in   1                     system clock, rising edge
//   rst_in          in   1                     async reset, ACTIVE-LOW (reset while 0)
//   enable_in       in   1                     1 = allowed to issue new dequeues
//   pq_empty_in     in   1                     PQ_FIFO empty_out
//   pq_data_in      in   DATA_WIDTH            PQ_FIFO data_out
//   pq_valid_in     in   1                     PQ_FIFO valid_out (1-cycle pulse per dequeue)
//   pq_deq_out      out  1                     to PQ_FIFO deq_in; 1-cycle pulse
//   m_prio_out      out  PRIO_WIDTH            head-of-buffer priority
//   m_payload_out   out  DATA_WIDTH-PRIO_WIDTH head-of-buffer payload
//   m_valid_out     out  1                     head entry valid
//   m_ready_in      in   1                     downstream accepts head this cycle
//   busy_out        out  1                     dequeue outstanding or buffer non-empty
//   pop_count_out   out  CNT_WIDTH             entries accepted downstream (wraps)
//   err_out         out  1                     sticky: a dequeue timed out
// BEHAVIOUR
//   Reset (rst_in=0, async): state=IDLE, buffer empty.
//     pq_deq_out=0, m_valid_out=0, m_prio_out=0, m_payload_out=0.
//     busy_out=0, pop_count_out=0, err_out=0. Timeout counter=0.
//   FSM with 2 states:
//     IDLE: if enable_in && !pq_empty_in && occupancy<2 -> pq_deq_out=1 (registered,
//       exactly one cycle), counter=0, go WAIT. Otherwise stay in IDLE.
//     WAIT: pq_deq_out=0; counter increments each cycle.
//       - pq_valid_in=1 -> write pq_data_in into buffer tail, go IDLE.
//       - counter==TIMEOUT without pq_valid_in -> err_out=1 (sticky until reset),
//         drop the request, go IDLE.
//   At most one dequeue is outstanding. No new pulse is issued in the cycle WAIT exits.
//   Minimum issue interval is 2 cycles plus the PQ response latency.
//   Occupancy check counts the outstanding dequeue, so a captured word always has a slot.
//   pq_valid_in outside WAIT is ignored: no capture, no error.
//   Split: prio = pq_data_in[DATA_WIDTH-1 -: PRIO_WIDTH];
//     payload = pq_data_in[DATA_WIDTH-PRIO_WIDTH-1:0]. No arithmetic on fields.
//   Output buffer: 2-entry FIFO, first in first out.
//     m_valid_out = (occupancy != 0). Head fields are driven from registers.
//     Fields hold their value until accepted.
//     Transfer when m_valid_out && m_ready_in: head is popped and pop_count_out+1
//       (wraps modulo 2^CNT_WIDTH).
//     Capture and transfer in the same cycle: both happen, occupancy unchanged, order kept.
//     Capture into an empty buffer: data appears on m_* the next cycle (1-cycle latency).
//   m_valid_out is not retracted and head data does not change while unaccepted.
//   enable_in=0 stops only new pulses. An outstanding dequeue still completes, and
//     buffered entries still drain.
//   pq_empty_in is sampled only in IDLE.
//   busy_out = (state==WAIT) || (occupancy != 0).
//   Reset mid-WAIT: request abandoned. A late pq_valid_in after reset is ignored (IDLE).
// TESTING
//   1 Reset, pq_empty_in=1, enable_in=1 -> pq_deq_out stays 0 and m_valid_out stays 0
//     for 20 cycles.
//   2 PQ model answering 1 cycle after deq with 0x0010_00AB, m_ready_in=1 -> exactly one
//     deq pulse. m_prio_out=0x0010, m_payload_out=0x00AB, 1-cycle valid,
//     pop_count_out=1.
//   3 Enqueue 64 then 16 into PQ_FIFO model, m_ready_in=0 -> 2 pops only (buffer full),
//     no 3rd pulse. Raise ready -> outputs 16 then 64, pop_count_out=2.
//   4 Capture and downstream accept in the same cycle with 1 entry held ->
//     occupancy stays 1, ordering preserved.
//   5 PQ never asserts valid -> err_out=1 exactly TIMEOUT cycles after entering WAIT,
//     FSM back in IDLE. Next dequeue still issues. err_out stays 1 until rst_in=0.
//   6 rst_in=0 asserted during WAIT, then late pq_valid_in -> all outputs at reset values,
//     no capture.

Source files
------------

// File: rtl/pq_pop_unit.sv
// pq_pop_unit: issues dequeues to PQ_FIFO, splits popped words into {priority, payload}
// and streams them through a 2-entry FIFO with a sticky dequeue-timeout flag.
module pq_pop_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int PRIO_WIDTH = 16,
  parameter int TIMEOUT    = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             enable_in,
  input  logic                             pq_empty_in,
  input  logic [DATA_WIDTH-1:0]            pq_data_in,
  input  logic                             pq_valid_in,
  output logic                             pq_deq_out,
  output logic [PRIO_WIDTH-1:0]            m_prio_out,
  output logic [DATA_WIDTH-PRIO_WIDTH-1:0] m_payload_out,
  output logic                             m_valid_out,
  input  logic                             m_ready_in,
  output logic                             busy_out,
  output logic [CNT_WIDTH-1:0]             pop_count_out,
  output logic                             err_out
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, nxt;
  logic [TW-1:0] cnt;
  logic [1:0] occ, occ_pop;
  logic [DATA_WIDTH-1:0] fifo [2];
  logic issue, cap, tmo, pop;
  always_comb begin
    pop = m_valid_out && m_ready_in;
    issue = state == IDLE && enable_in && !pq_empty_in && occ != 2'd2;
    cap = state == WAIT && pq_valid_in;
    tmo = state == WAIT && !pq_valid_in && cnt == TW'(TIMEOUT - 1);
    occ_pop = occ - {1'b0, pop};
    nxt = issue ? WAIT : (cap || tmo) ? IDLE : state;
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) state <= IDLE;
    else state <= nxt;
  // The slot freed by a same-cycle pop is reused by the capture, so order is kept.
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      pq_deq_out <= 1'b0;
      cnt <= '0;
      occ <= '0;
      fifo[0] <= '0;
      fifo[1] <= '0;
      pop_count_out <= '0;
      err_out <= 1'b0;
    end else begin
      pq_deq_out <= issue;
      cnt <= issue ? '0 : cnt + TW'(1);
      err_out <= err_out | tmo;
      if (pop) begin
        fifo[0] <= fifo[1];
        pop_count_out <= pop_count_out + CNT_WIDTH'(1);
      end
      if (cap) fifo[occ_pop[0]] <= pq_data_in;
      occ <= occ_pop + {1'b0, cap};
    end
  assign m_valid_out = occ != 2'd0;
  assign m_prio_out = fifo[0][DATA_WIDTH-1 -: PRIO_WIDTH];
  assign m_payload_out = fifo[0][DATA_WIDTH-PRIO_WIDTH-1:0];
  assign busy_out = state == WAIT || m_valid_out;
endmodule

// File: tb/tb_pq_pop_unit.sv
// tb_pq_pop_unit: priority-queue responder plus queue-based reference model of the pop unit,
// directed scenarios with literal expectations followed by a randomized run.
module tb_pq_pop_unit;
  localparam int DW = 32, PW = 16, T = 15, CW = 16;
  logic clk_in = 0, rst_in = 0, enable_in = 0, pq_empty_in = 1, pq_valid_in = 0, m_ready_in = 0;
  logic [DW-1:0] pq_data_in = '0;
  logic pq_deq_out, m_valid_out, busy_out, err_out;
  logic [PW-1:0] m_prio_out;
  logic [DW-PW-1:0] m_payload_out;
  logic [CW-1:0] pop_count_out;

  pq_pop_unit #(.DATA_WIDTH(DW), .PRIO_WIDTH(PW), .TIMEOUT(T), .CNT_WIDTH(CW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .pq_empty_in(pq_empty_in),
    .pq_data_in(pq_data_in), .pq_valid_in(pq_valid_in), .pq_deq_out(pq_deq_out),
    .m_prio_out(m_prio_out), .m_payload_out(m_payload_out), .m_valid_out(m_valid_out),
    .m_ready_in(m_ready_in), .busy_out(busy_out), .pop_count_out(pop_count_out), .err_out(err_out));

  always #5 clk_in = ~clk_in;

  int vectors = 0, miscompares = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // PQ_FIFO stand-in: min-first priority queue answering `lat` cycles after a dequeue
  logic [DW-1:0] pq[$];
  logic [DW-1:0] pend_word;
  int pend = 0, lat = 1, deq_seen = 0, ncyc = 0;
  bit no_resp = 0, rdy_on_cap = 0;

  task automatic drive_pq();
    int mi;
    pq_valid_in = 0;
    if (rdy_on_cap) m_ready_in = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        pq_valid_in = 1;
        pq_data_in = pend_word;
        if (rdy_on_cap) m_ready_in = 1;
      end
    end
    if (pq_deq_out) begin
      deq_seen++;
      if (pq.size() > 0) begin
        mi = 0;
        for (int i = 1; i < pq.size(); i++) if (pq[i] < pq[mi]) mi = i;
        pend_word = pq[mi];
        pq.delete(mi);
        pend = no_resp ? 0 : lat;
      end
    end
    pq_empty_in = pq.size() == 0;
  endtask

  task automatic step();
    @(negedge clk_in);
    ncyc++;
    drive_pq();
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    ncyc++;
    drive_pq();
    #1 rst_in = 0;
    #2 rst_in = 1;
  endtask

  // Reference model: buffer as a queue, outstanding request tracked by its age
  logic [DW-1:0] mq[$];
  bit outst, merr, mdeq, mp, mi_, mc, mt;
  int age;
  logic [CW-1:0] mcnt;
  always @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      mq.delete();
      outst = 0; age = 0; mcnt = 0; merr = 0; mdeq = 0;
    end else begin
      mp = mq.size() > 0 && m_ready_in;
      mi_ = !outst && enable_in && !pq_empty_in && mq.size() < 2;
      mc = outst && pq_valid_in;
      mt = outst && !pq_valid_in && (age + 1 == T);
      if (mp) begin
        void'(mq.pop_front());
        mcnt++;
      end
      if (mc) mq.push_back(pq_data_in);
      mdeq = mi_;
      if (mi_) begin
        outst = 1;
        age = 0;
      end else begin
        if (mc || mt) outst = 0;
        age++;
      end
      merr |= mt;
    end

  always @(negedge clk_in)
    if (rst_in) begin
      chk("deq", pq_deq_out, mdeq);
      chk("m_valid", m_valid_out, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("m_prio", m_prio_out, mq[0][DW-1 -: PW]);
        chk("m_payload", m_payload_out, mq[0][DW-PW-1:0]);
      end
      chk("busy", busy_out, outst || mq.size() > 0);
      chk("pop_count", pop_count_out, mcnt);
      chk("err", err_out, merr);
    end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_deq"}, pq_deq_out, 0);
    chk({tag, "_valid"}, m_valid_out, 0);
    chk({tag, "_prio"}, m_prio_out, 0);
    chk({tag, "_payload"}, m_payload_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_count"}, pop_count_out, 0);
    chk({tag, "_err"}, err_out, 0);
  endtask

  int n0;
  initial begin
    enable_in = 1;
    m_ready_in = 1;
    repeat (2) @(negedge clk_in);
    chk_reset_vals("reset");
    #1 rst_in = 1;
    repeat (20) begin
      step();
      chk("t1_deq", pq_deq_out, 0);
      chk("t1_valid", m_valid_out, 0);
    end

    do_reset();
    deq_seen = 0;
    pq.push_back(32'h0010_00AB);
    for (int k = 0; k < 20 && !m_valid_out; k++) step();
    chk("t2_valid", m_valid_out, 1);
    chk("t2_prio", m_prio_out, 16'h0010);
    chk("t2_payload", m_payload_out, 16'h00AB);
    step();
    chk("t2_valid_drop", m_valid_out, 0);
    chk("t2_count", pop_count_out, 1);
    chk("t2_deqs", deq_seen, 1);

    do_reset();
    deq_seen = 0;
    m_ready_in = 0;
    pq.push_back({16'd64, 16'h0001});
    pq.push_back({16'd16, 16'h0002});
    repeat (40) step();
    chk("t3_deqs", deq_seen, 2);
    chk("t3_valid", m_valid_out, 1);
    chk("t3_head0", m_prio_out, 16);
    m_ready_in = 1;
    step();
    chk("t3_head1", m_prio_out, 64);
    chk("t3_count1", pop_count_out, 1);
    step();
    chk("t3_count2", pop_count_out, 2);
    chk("t3_empty", m_valid_out, 0);

    do_reset();
    m_ready_in = 0;
    pq.push_back({16'd5, 16'h00AA});
    for (int k = 0; k < 20 && !m_valid_out; k++) step();
    rdy_on_cap = 1;
    pq.push_back({16'd9, 16'h00BB});
    for (int k = 0; k < 20 && pop_count_out == 0; k++) step();
    chk("t4_count", pop_count_out, 1);
    chk("t4_valid", m_valid_out, 1);
    chk("t4_head", m_prio_out, 9);
    rdy_on_cap = 0;
    m_ready_in = 0;
    step();
    chk("t4_hold_valid", m_valid_out, 1);
    chk("t4_hold_payload", m_payload_out, 16'h00BB);

    do_reset();
    deq_seen = 0;
    no_resp = 1;
    m_ready_in = 1;
    pq.push_back(32'h0003_0033);
    for (int k = 0; k < 20 && deq_seen == 0; k++) step();
    n0 = ncyc;
    for (int k = 0; k < 40 && !err_out; k++) step();
    chk("t5_err", err_out, 1);
    chk("t5_latency", 64'(ncyc - n0), T);
    chk("t5_idle", busy_out, 0);
    no_resp = 0;
    pq.push_back(32'h0004_0044);
    for (int k = 0; k < 40 && pop_count_out == 0; k++) step();
    chk("t5_redeq", deq_seen, 2);
    chk("t5_count", pop_count_out, 1);
    chk("t5_sticky", err_out, 1);

    do_reset();
    deq_seen = 0;
    lat = 3;
    pq.push_back(32'h0007_0077);
    for (int k = 0; k < 20 && deq_seen == 0; k++) step();
    step();
    do_reset();
    repeat (5) begin
      step();
      chk_reset_vals("t6");
    end

    do_reset();
    repeat (3000) begin
      step();
      enable_in = ($urandom % 4) != 0;
      m_ready_in = $urandom % 2;
      lat = ($urandom % 20 == 0) ? T + 3 : $urandom_range(1, 6);
      no_resp = $urandom % 40 == 0;
      if ($urandom % 3 == 0 && pq.size() < 8) pq.push_back($urandom);
      pq_empty_in = pq.size() == 0;
      if ($urandom % 7 == 0) pq_data_in = $urandom;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
